acc_write_sequencer: RTL and testbench
======================================

// Module: acc_write_sequencer
// PURPOSE
//   Write-side front end of the accumulator register file. Accepts write-back
//   requests {register, data} from the datapath over a valid/ready handshake,
//   buffers them in an in-order FIFO and drives the accumulator write port
//   (regWrite, RegisterNumber, writeData) with at most one write per cycle.
//   Also provides a combinational pending-write lookup for forwarding.
// PARAMETERS
//   DATA_W  8  width of writeData and wbData
//   ADDR_W  2  width of the register number (2**ADDR_W registers)
//   DEPTH   4  FIFO entries (power of 2, >= 2)
// PORTS
//   clock           in   1       rising-edge clock
//   reset_n         in   1       synchronous active-low reset
//   wbValid         in   1       write-back request valid
//   wbReady         out  1       sequencer can accept (= !full, 0 while reset_n=0)
//   wbRegNum        in   ADDR_W  target register of request
//   wbData          in   DATA_W  data of request
//   accStall        in   1       1 = do not issue a write this cycle
//   regWrite        out  1       registered write strobe to accumulator
//   RegisterNumber  out  ADDR_W  registered write address to accumulator
//   writeData       out  DATA_W  registered write data to accumulator
//   qRegNum         in   ADDR_W  forwarding query register
//   qHit            out  1       a pending/in-flight write targets qRegNum
//   qData           out  DATA_W  data of youngest such write (0 if !qHit)
//   issuedCount     out  8       writes issued since reset, wraps 255->0
// BEHAVIOUR
// - Reset (reset_n=0 at edge): FIFO emptied (pending writes dropped), regWrite=0,
//   RegisterNumber=0, writeData=0, issuedCount=0. Applies mid-operation too.
// - Push: at edge, wbValid & wbReady -> {wbRegNum,wbData} written at tail.
//   wbReady is derived from registered count only (no pass-through when full).
// - Issue: at edge, if FIFO non-empty & !accStall -> head popped, regWrite<=1,
//   RegisterNumber/writeData<=head, issuedCount+=1; else regWrite<=0 (addr/data
//   hold last value). regWrite is high for exactly one cycle per entry.
// - Latency: request accepted at edge k into empty FIFO -> regWrite high after
//   edge k+1; accumulator captures at edge k+2. Back-to-back: one write/cycle.
// - Push and pop in same cycle: both happen, count unchanged; legal at any
//   count < DEPTH. Pointers wrap modulo DEPTH.
// - Order: writes issued strictly in acceptance order; same-register writes
//   never reordered or merged.
// - accStall: blocks pop only; does not affect push. Stall during an asserted
//   regWrite does not extend it (write already presented completes).
// - Forwarding (combinational): search FIFO entries and the output register
//   (only when regWrite=1). Priority youngest FIFO entry > older entries >
//   output register. qData=0 when qHit=0.
// - No state machine beyond FIFO control; states implied by count: EMPTY
//   (wbReady=1, no issue), PARTIAL, FULL (wbReady=0).
// TESTING
//   1 Reset: hold reset_n=0 2 cycles with wbValid=1 -> wbReady=0, regWrite=0,
//     RegisterNumber=0, writeData=0, issuedCount=0, nothing accepted.
//   2 Single write: push {1,8'h03} -> regWrite=1 one cycle later with
//     RegisterNumber=1, writeData=3; next cycle regWrite=0, issuedCount=1.
//   3 Full/stall: accStall=1, push {0,A},{1,B},{2,C},{3,D} -> wbReady=0 after
//     4th; 5th request held; release stall -> 4 consecutive writes A,B,C,D
//     in order, wbReady=1 after first pop, 5th accepted.
//   4 Forwarding: accStall=1, push {2,5},{2,9} -> qRegNum=2 gives qHit=1,
//     qData=9; qRegNum=3 gives qHit=0, qData=0.
//   5 Simultaneous push/pop at count=2 for 6 cycles -> count stays 2, pointers
//     wrap, writes emerge in acceptance order, issuedCount=+6.
//   6 Reset mid-operation with 3 pending -> next cycle regWrite=0, FIFO empty,
//     no stale write issued after reset_n returns to 1.

Source files
------------

// File: rtl/acc_write_sequencer.sv
// Write-side front end of the accumulator register file: an in-order request FIFO
// feeding a registered accumulator write port, plus a combinational forwarding lookup.
module acc_write_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wbValid,
  output logic              wbReady,
  input  logic [ADDR_W-1:0] wbRegNum,
  input  logic [DATA_W-1:0] wbData,
  input  logic              accStall,
  output logic              regWrite,
  output logic [ADDR_W-1:0] RegisterNumber,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] qRegNum,
  output logic              qHit,
  output logic [DATA_W-1:0] qData,
  output logic [7:0]        issuedCount
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] regMem  [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // Ready comes from the registered count only, so a full FIFO never accepts
  // even when a pop happens in the same cycle.
  assign wbReady = reset_n && (count != CNT_W'(DEPTH));
  assign push    = wbValid && wbReady;
  assign pop     = (count != '0) && !accStall;

  always_ff @(posedge clock) begin
    if (push) begin
      regMem[wrPtr]  <= wbRegNum;
      dataMem[wrPtr] <= wbData;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wrPtr          <= '0;
      rdPtr          <= '0;
      count          <= '0;
      regWrite       <= 1'b0;
      RegisterNumber <= '0;
      writeData      <= '0;
      issuedCount    <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr          <= rdPtr + 1'b1;
        regWrite       <= 1'b1;
        RegisterNumber <= regMem[rdPtr];
        writeData      <= dataMem[rdPtr];
        issuedCount    <= issuedCount + 8'd1;
      end else begin
        regWrite <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins; the output
  // register is the oldest candidate and only counts while its strobe is up.
  always_comb begin
    qHit  = 1'b0;
    qData = '0;
    if (regWrite && (RegisterNumber == qRegNum)) begin
      qHit  = 1'b1;
      qData = writeData;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (regMem[rdPtr + PTR_W'(i)] == qRegNum)) begin
        qHit  = 1'b1;
        qData = dataMem[rdPtr + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_acc_write_sequencer.sv
// Directed bench for acc_write_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_acc_write_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       wbValid;
  logic       wbReady;
  logic [1:0] wbRegNum;
  logic [7:0] wbData;
  logic       accStall;
  logic       regWrite;
  logic [1:0] RegisterNumber;
  logic [7:0] writeData;
  logic [1:0] qRegNum;
  logic       qHit;
  logic [7:0] qData;
  logic [7:0] issuedCount;

  int total = 0;
  int bad   = 0;

  acc_write_sequencer #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .wbValid(wbValid), .wbReady(wbReady),
    .wbRegNum(wbRegNum), .wbData(wbData), .accStall(accStall), .regWrite(regWrite),
    .RegisterNumber(RegisterNumber), .writeData(writeData), .qRegNum(qRegNum),
    .qHit(qHit), .qData(qData), .issuedCount(issuedCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic expWrite(input string tag, input logic [1:0] rn, input logic [7:0] wd);
    chk({tag, "_regWrite"}, 32'(regWrite), 32'd1);
    chk({tag, "_regNum"}, 32'(RegisterNumber), 32'(rn));
    chk({tag, "_data"}, 32'(writeData), 32'(wd));
  endtask

  initial begin
    reset_n = 1'b0; wbValid = 1'b1; wbRegNum = 2'd1; wbData = 8'hEE;
    accStall = 1'b0; qRegNum = 2'd1;

    // 1: reset held two cycles with a request pending
    tick(); tick();
    chk("rst_wbReady", 32'(wbReady), 32'd0);
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_regNum", 32'(RegisterNumber), 32'd0);
    chk("rst_data", 32'(writeData), 32'd0);
    chk("rst_issued", 32'(issuedCount), 32'd0);
    wbValid = 1'b0; reset_n = 1'b1;
    tick(); tick();
    chk("rst_noAccept_regWrite", 32'(regWrite), 32'd0);
    chk("rst_noAccept_qHit", 32'(qHit), 32'd0);
    chk("rst_noAccept_issued", 32'(issuedCount), 32'd0);
    chk("rst_release_wbReady", 32'(wbReady), 32'd1);

    // 2: single write {1,03}
    wbValid = 1'b1; wbRegNum = 2'd1; wbData = 8'h03;
    tick();
    wbValid = 1'b0;
    chk("single_notYet", 32'(regWrite), 32'd0);
    tick();
    expWrite("single", 2'd1, 8'h03);
    chk("single_issued1", 32'(issuedCount), 32'd1);
    tick();
    chk("single_strobeDrop", 32'(regWrite), 32'd0);
    chk("single_addrHold", 32'(RegisterNumber), 32'd1);
    chk("single_issued", 32'(issuedCount), 32'd1);

    // 3: fill under stall, fifth request held, then drain
    accStall = 1'b1; wbValid = 1'b1;
    wbRegNum = 2'd0; wbData = 8'hA1; tick();
    wbRegNum = 2'd1; wbData = 8'hB2; tick();
    wbRegNum = 2'd2; wbData = 8'hC3; tick();
    chk("full_readyAt3", 32'(wbReady), 32'd1);
    wbRegNum = 2'd3; wbData = 8'hD4; tick();
    chk("full_readyAt4", 32'(wbReady), 32'd0);
    wbRegNum = 2'd1; wbData = 8'h5E; tick();
    chk("full_held_ready", 32'(wbReady), 32'd0);
    chk("full_held_regWrite", 32'(regWrite), 32'd0);
    accStall = 1'b0;
    tick();
    expWrite("drainA", 2'd0, 8'hA1);
    chk("drain_readyAfterPop", 32'(wbReady), 32'd1);
    tick();
    wbValid = 1'b0;
    expWrite("drainB", 2'd1, 8'hB2);
    tick();
    expWrite("drainC", 2'd2, 8'hC3);
    tick();
    expWrite("drainD", 2'd3, 8'hD4);
    tick();
    expWrite("drain5th", 2'd1, 8'h5E);
    tick();
    chk("drain_idle", 32'(regWrite), 32'd0);
    chk("drain_issued", 32'(issuedCount), 32'd6);

    // 4: forwarding, youngest of two writes to r2
    accStall = 1'b1; wbValid = 1'b1;
    wbRegNum = 2'd2; wbData = 8'h05; tick();
    wbRegNum = 2'd2; wbData = 8'h09; tick();
    wbValid = 1'b0;
    qRegNum = 2'd2; #1;
    chk("fwd_hit", 32'(qHit), 32'd1);
    chk("fwd_youngest", 32'(qData), 32'h09);
    qRegNum = 2'd3; #1;
    chk("fwd_miss", 32'(qHit), 32'd0);
    chk("fwd_missData", 32'(qData), 32'd0);
    qRegNum = 2'd2;
    accStall = 1'b0;
    tick();
    expWrite("fwd_pop5", 2'd2, 8'h05);
    chk("fwd_fifoOverOut", 32'(qData), 32'h09);
    tick();
    expWrite("fwd_pop9", 2'd2, 8'h09);
    chk("fwd_outReg_hit", 32'(qHit), 32'd1);
    chk("fwd_outReg_data", 32'(qData), 32'h09);
    tick();
    chk("fwd_gone_hit", 32'(qHit), 32'd0);
    chk("fwd_gone_data", 32'(qData), 32'd0);
    chk("fwd_issued", 32'(issuedCount), 32'd8);

    // 5: simultaneous push/pop at count=2 for six cycles
    accStall = 1'b1; wbValid = 1'b1;
    wbRegNum = 2'd0; wbData = 8'h10; tick();
    wbRegNum = 2'd1; wbData = 8'h11; tick();
    accStall = 1'b0;
    wbRegNum = 2'd2; wbData = 8'h12; tick(); expWrite("pp0", 2'd0, 8'h10);
    wbRegNum = 2'd3; wbData = 8'h13; tick(); expWrite("pp1", 2'd1, 8'h11);
    wbRegNum = 2'd0; wbData = 8'h14; tick(); expWrite("pp2", 2'd2, 8'h12);
    wbRegNum = 2'd1; wbData = 8'h15; tick(); expWrite("pp3", 2'd3, 8'h13);
    wbRegNum = 2'd2; wbData = 8'h16; tick(); expWrite("pp4", 2'd0, 8'h14);
    wbRegNum = 2'd3; wbData = 8'h17; tick(); expWrite("pp5", 2'd1, 8'h15);
    chk("pp_ready", 32'(wbReady), 32'd1);
    wbValid = 1'b0; accStall = 1'b1;
    tick();
    chk("pp_stallIdle", 32'(regWrite), 32'd0);
    chk("pp_issued", 32'(issuedCount), 32'd14);
    accStall = 1'b0;
    tick(); expWrite("pp_tail6", 2'd2, 8'h16);
    tick(); expWrite("pp_tail7", 2'd3, 8'h17);
    tick();
    chk("pp_emptyAfter2", 32'(regWrite), 32'd0);
    chk("pp_issuedEnd", 32'(issuedCount), 32'd16);

    // 6: reset with three writes pending
    accStall = 1'b1; wbValid = 1'b1;
    wbRegNum = 2'd3; wbData = 8'h31; tick();
    wbRegNum = 2'd2; wbData = 8'h32; tick();
    wbRegNum = 2'd1; wbData = 8'h33; tick();
    wbValid = 1'b0; accStall = 1'b0; reset_n = 1'b0;
    tick();
    chk("midRst_regWrite", 32'(regWrite), 32'd0);
    chk("midRst_ready", 32'(wbReady), 32'd0);
    chk("midRst_issued", 32'(issuedCount), 32'd0);
    chk("midRst_regNum", 32'(RegisterNumber), 32'd0);
    chk("midRst_data", 32'(writeData), 32'd0);
    qRegNum = 2'd3; #1;
    chk("midRst_qHit", 32'(qHit), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("postRst_regWrite0", 32'(regWrite), 32'd0);
    tick();
    chk("postRst_regWrite1", 32'(regWrite), 32'd0);
    chk("postRst_issued", 32'(issuedCount), 32'd0);
    chk("postRst_ready", 32'(wbReady), 32'd1);
    qRegNum = 2'd1; #1;
    chk("postRst_qHit", 32'(qHit), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
